// File: rtl/cache_meta_ctrl_pkg.sv
// Shared constants and types for the 2-way cache lookup / miss-fill controller.
package cache_meta_ctrl_pkg;

  localparam int TAG_MSB   = 7;
  localparam int TAG_LSB   = 2;
  localparam int VALID_BIT = 1;
  localparam int LRU_BIT   = 0;

  localparam int TAG_W  = 6;
  localparam int SET_W  = 6;
  localparam int WORD_W = 3;
  localparam int SETS   = 64;

  localparam int ADDR_TAG_MSB = 15;
  localparam int ADDR_TAG_LSB = 10;
  localparam int ADDR_SET_MSB = 9;
  localparam int ADDR_SET_LSB = 4;

  localparam int WORDS_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    META = 2'd2
  } state_t;

  function automatic logic [7:0] meta_pack(input logic [TAG_W-1:0] tag,
                                           input logic valid,
                                           input logic lru);
    return {tag, valid, lru};
  endfunction

endpackage

// File: rtl/cache_meta_ctrl_set_decoder.sv
// 6-to-64 one-hot set decoder, shared between metadata and data array sides.
module set_decoder
  import cache_meta_ctrl_pkg::*;
(
  input  logic [SET_W-1:0] set,
  output logic [SETS-1:0]  onehot
);

  assign onehot = {{(SETS-1){1'b0}}, 1'b1} << set;

endmodule

// File: rtl/cache_meta_ctrl.sv
// Lookup and miss-fill controller for a 2-way set-associative cache.
// Victim policy for full sets: true LRU when CACHE_LRU_EN is defined, round-robin otherwise.
module cache_meta_ctrl
  import cache_meta_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        stall,
  output logic        hit,
  output logic [63:0] meta_block_enable,
  input  logic [7:0]  meta0_out,
  input  logic [7:0]  meta1_out,
  output logic [7:0]  meta0_in,
  output logic [7:0]  meta1_in,
  output logic        meta0_write,
  output logic        meta1_write,
  output logic        hit_way,
  output logic        data_write,
  output logic [7:0]  data_word_enable,
  output logic        fill_way,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data
);

`ifdef CACHE_LRU_EN
  localparam logic FILL_OTHER_LRU = 1'b1;
`else
  localparam logic FILL_OTHER_LRU = 1'b0;
`endif

  state_t              state;
  logic [TAG_W-1:0]    tag_q;
  logic [SET_W-1:0]    set_q;
  logic [WORD_W-1:0]   issue_cnt;
  logic [WORD_W-1:0]   rcv_cnt;
  logic                issue_done;

  logic [TAG_W-1:0]    addr_tag;
  logic [SET_W-1:0]    addr_set;
  logic [SET_W-1:0]    set_sel;
  logic [TAG_W-1:0]    tag0;
  logic [TAG_W-1:0]    tag1;
  logic                valid0;
  logic                valid1;
  logic                lru0;
  logic                lru1;
  logic                match0;
  logic                match1;
  logic                any_match;
  logic                full_victim;
  logic                victim_sel;

  assign addr_tag = addr[ADDR_TAG_MSB:ADDR_TAG_LSB];
  assign addr_set = addr[ADDR_SET_MSB:ADDR_SET_LSB];
  assign tag0     = meta0_out[TAG_MSB:TAG_LSB];
  assign tag1     = meta1_out[TAG_MSB:TAG_LSB];
  assign valid0   = meta0_out[VALID_BIT];
  assign valid1   = meta1_out[VALID_BIT];
  assign lru0     = meta0_out[LRU_BIT];
  assign lru1     = meta1_out[LRU_BIT];
  assign match0   = valid0 && (tag0 == addr_tag);
  assign match1   = valid1 && (tag1 == addr_tag);
  assign any_match = match0 || match1;

  // Word offset and returned data go straight to the data arrays, not through here.
  logic unused_inputs;
  assign unused_inputs = ^{addr[3:0], mem_data, lru0, lru1, MEM_LAT[0]};

`ifdef CACHE_LRU_EN
  assign full_victim = ~lru0 & lru1;
`else
  logic rr_q;
  assign full_victim = rr_q;
`endif

  always_comb begin
    if (!valid0)      victim_sel = 1'b0;
    else if (!valid1) victim_sel = 1'b1;
    else              victim_sel = full_victim;
  end

  // Once a miss is taken the latched set steers the arrays, so addr may wander.
  assign set_sel = (state == IDLE) ? addr_set : set_q;

  set_decoder u_set_decoder (
    .set    (set_sel),
    .onehot (meta_block_enable)
  );

  always_comb begin
    stall            = 1'b0;
    hit              = 1'b0;
    hit_way          = 1'b0;
    meta0_in         = 8'h00;
    meta1_in         = 8'h00;
    meta0_write      = 1'b0;
    meta1_write      = 1'b0;
    data_write       = 1'b0;
    data_word_enable = 8'h00;
    mem_read         = 1'b0;
    mem_addr         = 16'h0000;
    case (state)
      IDLE: begin
        hit   = req && any_match;
        stall = req && !any_match;
        if (req && any_match) begin
          hit_way = ~match0;
`ifdef CACHE_LRU_EN
          meta0_in    = meta_pack(tag0, valid0, ~match0);
          meta1_in    = meta_pack(tag1, valid1, match0);
          meta0_write = 1'b1;
          meta1_write = 1'b1;
`endif
        end
      end
      FILL: begin
        stall = 1'b1;
        if (!issue_done) begin
          mem_read = 1'b1;
          mem_addr = {tag_q, set_q, issue_cnt, 1'b0};
        end
        if (mem_data_valid) begin
          data_write       = 1'b1;
          data_word_enable = 8'd1 << rcv_cnt;
        end
      end
      META: begin
        stall       = 1'b1;
        meta0_write = 1'b1;
        meta1_write = 1'b1;
        if (fill_way == 1'b0) begin
          meta0_in = meta_pack(tag_q, 1'b1, 1'b0);
          meta1_in = meta_pack(tag1, valid1, FILL_OTHER_LRU);
        end else begin
          meta0_in = meta_pack(tag0, valid0, FILL_OTHER_LRU);
          meta1_in = meta_pack(tag_q, 1'b1, 1'b0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tag_q      <= '0;
      set_q      <= '0;
      fill_way   <= 1'b0;
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      issue_done <= 1'b0;
`ifndef CACHE_LRU_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req && !any_match) begin
            tag_q      <= addr_tag;
            set_q      <= addr_set;
            fill_way   <= victim_sel;
            issue_cnt  <= '0;
            rcv_cnt    <= '0;
            issue_done <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (!issue_done) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == WORD_W'(WORDS_PER_BLOCK - 1)) issue_done <= 1'b1;
          end
          if (mem_data_valid) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == WORD_W'(WORDS_PER_BLOCK - 1)) state <= META;
          end
        end
        META: begin
          issue_done <= 1'b0;
          state      <= IDLE;
`ifndef CACHE_LRU_EN
          rr_q       <= ~rr_q;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
